usb_tx_encoder: RTL and testbench

USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

---
 rtl/usb_pkg.sv | 35 +++
 rtl/usb_tx_timer.sv | 39 +++
 rtl/usb_tx_encoder.sv | 173 +++++++++++++++++
 tb/tb_usb_tx_encoder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// usb_pkg : shared types and line-state constants for the USB FS transmitter
// Revision: 1.0
// ============================================================================
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_DATA    = 3'd2,
    ST_EOP_SE0 = 3'd3,
    ST_EOP_J   = 3'd4
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'h80;
  localparam logic [2:0] STUFF_LIMIT = 3'd6;

  // {d_plus, d_minus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic raw);
    logic [1:0] result;
    if (raw) begin
      result = line;
    end else begin
      result = (line == LINE_J) ? LINE_K : LINE_J;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_timer.sv
`default_nettype none
// ============================================================================
// usb_tx_timer : bit-period divider with start/end strobes and a clear input
// Revision: 1.0
// ============================================================================
module usb_tx_timer
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  output logic bit_start,
  output logic bit_end,
  output logic pre_end
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_start = (cnt == '0);
  assign bit_end   = (cnt == CW'(CLKS_PER_BIT - 1));
  // one cycle ahead of bit_end, lets registered handshakes land on the last cycle
  assign pre_end   = (cnt == CW'(CLKS_PER_BIT - 2));

endmodule
`default_nettype wire

// File: rtl/usb_tx_encoder.sv
`default_nettype none
// ============================================================================
// usb_tx_encoder : USB full-speed packet serializer (SYNC, NRZI, stuffing, EOP)
// Revision: 1.0
// ============================================================================
module usb_tx_encoder
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  tx_state_t  state, state_next;
  logic [2:0] bit_idx, bit_idx_next;
  logic [2:0] ones, ones_next;
  logic [7:0] shift, shift_next;
  logic       last, last_next;
  logic       aborted, aborted_next;
  logic [1:0] line, line_next;
  logic       ready_next, busy_next, done_next, error_next;
  logic       bit_start, bit_end, pre_end;
  logic       in_payload, stuff_due, need_byte;

  usb_tx_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (state == ST_IDLE),
    .bit_start(bit_start),
    .bit_end  (bit_end),
    .pre_end  (pre_end)
  );

  assign line       = {d_plus, d_minus};
  assign in_payload = (state == ST_SYNC) || (state == ST_DATA);
  assign stuff_due  = in_payload && (ones == STUFF_LIMIT);
  assign need_byte  = in_payload && (bit_idx == 3'd7) && !stuff_due &&
                      !((state == ST_DATA) && last);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      bit_idx  <= '0;
      ones     <= '0;
      shift    <= '0;
      last     <= 1'b0;
      aborted  <= 1'b0;
      d_plus   <= 1'b1;
      d_minus  <= 1'b0;
      tx_ready <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      state    <= state_next;
      bit_idx  <= bit_idx_next;
      ones     <= ones_next;
      shift    <= shift_next;
      last     <= last_next;
      aborted  <= aborted_next;
      d_plus   <= line_next[1];
      d_minus  <= line_next[0];
      tx_ready <= ready_next;
      tx_busy  <= busy_next;
      tx_done  <= done_next;
      tx_error <= error_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (tx_valid) state_next = ST_SYNC;
      ST_SYNC,
      ST_DATA:    if (bit_end && !stuff_due && (bit_idx == 3'd7)) begin
                    state_next = (need_byte && tx_ready) ? ST_DATA : ST_EOP_SE0;
                  end
      ST_EOP_SE0: if (bit_end && (bit_idx == 3'd1)) state_next = ST_EOP_J;
      ST_EOP_J:   if (bit_end) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bit_idx_next = bit_idx;
    ones_next    = ones;
    shift_next   = shift;
    last_next    = last;
    aborted_next = aborted;
    line_next    = line;
    ready_next   = 1'b0;
    done_next    = 1'b0;
    error_next   = 1'b0;
    busy_next    = (state_next != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          shift_next   = SYNC_BYTE;
          bit_idx_next = '0;
          ones_next    = SYNC_BYTE[0] ? 3'd1 : 3'd0;
          line_next    = nrzi_next(LINE_J, SYNC_BYTE[0]);
          last_next    = 1'b0;
          aborted_next = 1'b0;
        end
      end
      ST_SYNC, ST_DATA: begin
        ready_next = pre_end && need_byte && tx_valid;
        if (bit_end) begin
          if (stuff_due) begin
            line_next = nrzi_next(line, 1'b0);
            ones_next = '0;
          end else if (bit_idx != 3'd7) begin
            shift_next   = {1'b0, shift[7:1]};
            bit_idx_next = bit_idx + 3'd1;
            line_next    = nrzi_next(line, shift[1]);
            ones_next    = shift[1] ? ones + 3'd1 : 3'd0;
          end else if (need_byte && tx_ready) begin
            shift_next   = tx_data;
            last_next    = tx_last;
            bit_idx_next = '0;
            line_next    = nrzi_next(line, tx_data[0]);
            ones_next    = tx_data[0] ? ones + 3'd1 : 3'd0;
          end else begin
            // either the final byte is out or the source ran dry
            line_next    = LINE_SE0;
            bit_idx_next = '0;
            if (need_byte) begin
              error_next   = 1'b1;
              aborted_next = 1'b1;
            end
          end
        end
      end
      ST_EOP_SE0: begin
        if (bit_end) begin
          if (bit_idx == 3'd1) begin
            line_next    = LINE_J;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      ST_EOP_J: begin
        if (bit_end) begin
          done_next    = !aborted;
          ones_next    = '0;
          shift_next   = '0;
          bit_idx_next = '0;
          last_next    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  a_line_on_bit_start: assert property (@(posedge clk) disable iff (!n_rst)
    !$stable({d_plus, d_minus}) |-> bit_start);

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_encoder.sv
`default_nettype none
// ============================================================================
// tb_usb_tx_encoder : randomized packets checked against a bit-stream model
// Revision: 1.0
// ============================================================================
module tb_usb_tx_encoder;

  localparam int N = 4;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_ready, d_plus, d_minus, tx_busy, tx_done, tx_error;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  usb_tx_encoder #(.CLKS_PER_BIT(N)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_last (tx_last),
    .tx_ready(tx_ready),
    .d_plus  (d_plus),
    .d_minus (d_minus),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx_error(tx_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected line level per bit period, built from the packet bytes.
  logic [7:0] pkt[$];
  logic [1:0] exp_line[$];
  int         exp_ready[$];
  int         eop_start;
  int         ones_m;
  logic [1:0] cur_m;

  task automatic put_bit(input logic b);
    if (!b) cur_m = (cur_m == J) ? K : J;
    ones_m = b ? ones_m + 1 : 0;
    exp_line.push_back(cur_m);
    if (ones_m == 6) begin
      cur_m = (cur_m == J) ? K : J;
      exp_line.push_back(cur_m);
      ones_m = 0;
    end
  endtask

  task automatic build_model();
    logic [7:0] sb = 8'h80;
    exp_line.delete();
    exp_ready.delete();
    cur_m  = J;
    ones_m = 0;
    for (int i = 0; i < 8; i++) put_bit(sb[i]);
    exp_ready.push_back(exp_line.size() - 1);
    for (int k = 0; k < pkt.size(); k++) begin
      for (int i = 0; i < 8; i++) put_bit(pkt[k][i]);
      if (k < pkt.size() - 1) exp_ready.push_back(exp_line.size() - 1);
    end
    eop_start = exp_line.size();
    exp_line.push_back(SE0);
    exp_line.push_back(SE0);
    exp_line.push_back(J);
  endtask

  task automatic run_packet(input bit underrun, input int gap, input int abort_at);
    int         total;
    int         idx;
    bit         consumed;
    logic [1:0] exp_l;
    bit         exp_r;
    build_model();
    total = exp_line.size() * N;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'($urandom);
    tx_last  = 1'($urandom);
    idx      = 0;
    consumed = 1'b0;
    for (int c = 0; c < total + gap; c++) begin
      @(negedge clk);
      if (consumed) idx++;
      exp_l = (c < total) ? exp_line[c / N] : J;
      exp_r = 1'b0;
      foreach (exp_ready[r]) if (c == exp_ready[r] * N + N - 1) exp_r = 1'b1;
      check_eq("line", {d_plus, d_minus}, exp_l);
      check_eq("tx_ready", tx_ready, exp_r);
      check_eq("tx_busy", tx_busy, c < total);
      check_eq("tx_done", tx_done, !underrun && (c == total));
      check_eq("tx_error", tx_error, underrun && (c == eop_start * N));
      if (c == abort_at) begin
        #1 n_rst = 1'b0;
        tx_valid = 1'b0;
        #1;
        check_eq("rst_d_plus", d_plus, 1'b1);
        check_eq("rst_d_minus", d_minus, 1'b0);
        check_eq("rst_tx_busy", tx_busy, 1'b0);
        check_eq("rst_tx_ready", tx_ready, 1'b0);
        @(negedge clk);
        #1 n_rst = 1'b1;
        return;
      end
      consumed = tx_ready;
      if (idx < pkt.size()) begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          tx_data = pkt[idx];
          tx_last = !underrun && (idx == pkt.size() - 1);
        end else begin
          tx_data = 8'($urandom);
          tx_last = 1'($urandom);
        end
      end else begin
        tx_valid = (!underrun && (c < total - 1)) ? 1'($urandom_range(0, 1)) : 1'b0;
        tx_data  = 8'($urandom);
        tx_last  = 1'($urandom);
      end
    end
  endtask

  // Line-level run lengths inside a packet must be whole bit periods.
  logic [1:0] prev_l;
  int         run_len;
  bit         tracking;
  initial begin
    prev_l = J;
    run_len = 0;
    tracking = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        prev_l = J;
        run_len = 0;
        tracking = 1'b0;
      end else if ({d_plus, d_minus} != prev_l) begin
        if (tracking) check_eq("level_len", run_len % N, 0);
        prev_l = {d_plus, d_minus};
        run_len = 1;
        tracking = tx_busy;
      end else if (tracking && !tx_busy) begin
        check_eq("level_len", run_len % N, 0);
        tracking = 1'b0;
      end else begin
        run_len++;
      end
    end
  end

  a_no_se1: assert property (@(posedge clk) !(d_plus && d_minus))
    else $error("FAIL line_se1: both lines driven high");

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_eq("reset_d_plus", d_plus, 1'b1);
    check_eq("reset_d_minus", d_minus, 1'b0);
    check_eq("reset_tx_ready", tx_ready, 1'b0);
    check_eq("reset_tx_busy", tx_busy, 1'b0);
    check_eq("reset_tx_done", tx_done, 1'b0);
    check_eq("reset_tx_error", tx_error, 1'b0);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);

    pkt.delete(); pkt.push_back(8'h00);
    run_packet(1'b0, 3, -1);
    pkt.delete(); pkt.push_back(8'hFF);
    run_packet(1'b0, 3, -1);
    pkt.delete(); pkt.push_back(8'hC3); pkt.push_back(8'h3C);
    run_packet(1'b0, 3, -1);
    pkt.delete(); pkt.push_back(8'hA5);
    run_packet(1'b1, 3, -1);

    // reset lands in DATA bit 3 of the first byte
    pkt.delete(); pkt.push_back(8'h5A); pkt.push_back(8'h96);
    run_packet(1'b0, 0, (8 + 3) * N + 1);
    pkt.delete(); pkt.push_back(8'h81);
    run_packet(1'b0, 2, -1);

    for (int p = 0; p < 30; p++) begin
      n = $urandom_range(1, 4);
      pkt.delete();
      for (int i = 0; i < n; i++) begin
        pkt.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      end
      run_packet(($urandom_range(0, 4) == 0), $urandom_range(1, 6), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
